// File: rtl/dma_arbiter.sv
// dma_arbiter: single-channel byte DMA sharing a dual-lane (even/odd byte) memory port
// with a CPU. The CPU always wins the port. The DMA steals idle cycles to copy one
// byte per READ -> LATCH -> WRITE sequence.
//
// Optional feature macro: DMA_ARBITER_FILL_EN
//   defined   : ctrl bit2 (fill) writes src[7:0] as a constant byte, one byte per cycle
//   undefined : ctrl bit2 ignored, every transfer is a copy
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata    register write (0 src, 1 dst, 2 len, 3 ctrl)
//                                ctrl: bit0 start, bit1 irq_en, bit2 fill, bit3 abort
//   cpu_*                        CPU side of the memory port, cpu_active = CPU owns it
//   mem_*                        memory port (read data valid one cycle after address)
//   busy, done, irq              status: transfer running, sticky completion, interrupt
module dma_arbiter #(
  parameter int unsigned LENBITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cpu_active,
  input  logic [14:0] cpu_read_addr_even,
  input  logic [14:0] cpu_read_addr_odd,
  input  logic [14:0] cpu_write_addr_even,
  input  logic [14:0] cpu_write_addr_odd,
  input  logic        cpu_write_en_even,
  input  logic        cpu_write_en_odd,
  input  logic [7:0]  cpu_write_data_even,
  input  logic [7:0]  cpu_write_data_odd,
  output logic [14:0] mem_read_addr_even,
  output logic [14:0] mem_read_addr_odd,
  output logic [14:0] mem_write_addr_even,
  output logic [14:0] mem_write_addr_odd,
  output logic        mem_write_en_even,
  output logic        mem_write_en_odd,
  output logic [7:0]  mem_write_data_even,
  output logic [7:0]  mem_write_data_odd,
  input  logic [7:0]  mem_read_data_even,
  input  logic [7:0]  mem_read_data_odd,
  output logic        busy,
  output logic        done,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StRead, StLatch, StWrite} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [15:0]          r_src;
  logic [15:0]          r_dst;
  logic [LENBITS-1:0]   r_len;
  logic [7:0]           r_buf;
  logic                 r_irq_en;
  logic                 r_done;
  logic                 r_irq;

  logic w_ctrl_wr;
  logic w_start;
  logic w_abort;
  logic w_len_zero;
  logic w_len_last;
  logic w_dma_own;
  logic w_dma_write;
  logic w_fill;
  logic w_fill_req;
  logic [7:0] w_wr_byte;

  assign w_ctrl_wr  = cfg_we && (cfg_addr == 2'd3);
  assign w_abort    = w_ctrl_wr && cfg_wdata[3];
  // Start with abort in the same write counts as abort only.
  assign w_start    = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[3] && (r_state == StIdle);
  assign w_len_zero = (r_len == '0);
  assign w_len_last = (r_len == LENBITS'(1));
  assign w_dma_own  = !cpu_active && ((r_state == StRead) || (r_state == StWrite));
  assign w_dma_write = (r_state == StWrite) && !cpu_active && !w_abort;
  assign w_wr_byte  = w_fill ? r_src[7:0] : r_buf;

  assign busy = (r_state != StIdle);
  assign done = r_done;
  assign irq  = r_irq;

`ifdef DMA_ARBITER_FILL_EN
  logic r_fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= 1'b0;
    end else if (w_ctrl_wr && (r_state == StIdle)) begin
      r_fill <= cfg_wdata[2];
    end
  end

  assign w_fill     = r_fill;
  // The start write itself may carry fill, so route from the incoming data.
  assign w_fill_req = cfg_wdata[2];
`else
  assign w_fill     = 1'b0;
  assign w_fill_req = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start && !w_len_zero) begin
          w_state_next = w_fill_req ? StWrite : StRead;
        end
      end
      StRead: begin
        if (w_abort)          w_state_next = StIdle;
        else if (!cpu_active) w_state_next = StLatch;
      end
      StLatch: begin
        w_state_next = w_abort ? StIdle : StWrite;
      end
      StWrite: begin
        if (w_abort) begin
          w_state_next = StIdle;
        end else if (!cpu_active) begin
          if (w_len_last)  w_state_next = StIdle;
          else if (w_fill) w_state_next = StWrite;
          else             w_state_next = StRead;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Port mux: CPU values pass through unless the DMA owns this cycle.
  always_comb begin
    mem_read_addr_even  = cpu_read_addr_even;
    mem_read_addr_odd   = cpu_read_addr_odd;
    mem_write_addr_even = cpu_write_addr_even;
    mem_write_addr_odd  = cpu_write_addr_odd;
    mem_write_en_even   = cpu_write_en_even;
    mem_write_en_odd    = cpu_write_en_odd;
    mem_write_data_even = cpu_write_data_even;
    mem_write_data_odd  = cpu_write_data_odd;
    if (w_dma_own) begin
      mem_write_en_even = 1'b0;
      mem_write_en_odd  = 1'b0;
      if (r_state == StRead) begin
        if (r_src[0]) mem_read_addr_odd  = r_src[15:1];
        else          mem_read_addr_even = r_src[15:1];
      end else if (w_dma_write) begin
        if (r_dst[0]) begin
          mem_write_en_odd    = 1'b1;
          mem_write_addr_odd  = r_dst[15:1];
          mem_write_data_odd  = w_wr_byte;
        end else begin
          mem_write_en_even   = 1'b1;
          mem_write_addr_even = r_dst[15:1];
          mem_write_data_even = w_wr_byte;
        end
      end
    end
  end

  // Configuration and transfer datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_buf    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (cfg_we && (r_state == StIdle)) begin
        case (cfg_addr)
          2'd0:    r_src <= cfg_wdata;
          2'd1:    r_dst <= cfg_wdata;
          2'd2:    r_len <= cfg_wdata[LENBITS-1:0];
          default: ;
        endcase
      end
      if (w_ctrl_wr) r_irq_en <= cfg_wdata[1];
      // Zero-length start completes immediately; otherwise done is cleared.
      if (w_start) r_done <= w_len_zero;
      // Read data is valid here whether or not the CPU holds the port.
      if (r_state == StLatch) r_buf <= r_src[0] ? mem_read_data_odd : mem_read_data_even;
      if (w_dma_write) begin
        if (!w_fill) r_src <= r_src + 16'd1;
        r_dst <= r_dst + 16'd1;
        r_len <= r_len - LENBITS'(1);
        if (w_len_last) r_done <= 1'b1;
      end
      r_irq <= r_done & r_irq_en;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
module tb_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cpu_active;
  logic [14:0] cpu_read_addr_even, cpu_read_addr_odd;
  logic [14:0] cpu_write_addr_even, cpu_write_addr_odd;
  logic        cpu_write_en_even, cpu_write_en_odd;
  logic [7:0]  cpu_write_data_even, cpu_write_data_odd;
  logic [14:0] mem_read_addr_even, mem_read_addr_odd;
  logic [14:0] mem_write_addr_even, mem_write_addr_odd;
  logic        mem_write_en_even, mem_write_en_odd;
  logic [7:0]  mem_write_data_even, mem_write_data_odd;
  logic [7:0]  mem_read_data_even, mem_read_data_odd;
  logic        busy, done, irq;

  always #5 clk = ~clk;

  dma_arbiter #(.LENBITS(16)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_we              (cfg_we),
    .cfg_addr            (cfg_addr),
    .cfg_wdata           (cfg_wdata),
    .cpu_active          (cpu_active),
    .cpu_read_addr_even  (cpu_read_addr_even),
    .cpu_read_addr_odd   (cpu_read_addr_odd),
    .cpu_write_addr_even (cpu_write_addr_even),
    .cpu_write_addr_odd  (cpu_write_addr_odd),
    .cpu_write_en_even   (cpu_write_en_even),
    .cpu_write_en_odd    (cpu_write_en_odd),
    .cpu_write_data_even (cpu_write_data_even),
    .cpu_write_data_odd  (cpu_write_data_odd),
    .mem_read_addr_even  (mem_read_addr_even),
    .mem_read_addr_odd   (mem_read_addr_odd),
    .mem_write_addr_even (mem_write_addr_even),
    .mem_write_addr_odd  (mem_write_addr_odd),
    .mem_write_en_even   (mem_write_en_even),
    .mem_write_en_odd    (mem_write_en_odd),
    .mem_write_data_even (mem_write_data_even),
    .mem_write_data_odd  (mem_write_data_odd),
    .mem_read_data_even  (mem_read_data_even),
    .mem_read_data_odd   (mem_read_data_odd),
    .busy                (busy),
    .done                (done),
    .irq                 (irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory behind the two lanes, plus a byte-level reference image.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    mem_read_data_even <= mem[{mem_read_addr_even, 1'b0}];
    mem_read_data_odd  <= mem[{mem_read_addr_odd, 1'b1}];
    if (mem_write_en_even) mem[{mem_write_addr_even, 1'b0}] <= mem_write_data_even;
    if (mem_write_en_odd)  mem[{mem_write_addr_odd, 1'b1}]  <= mem_write_data_odd;
  end

  // Expected DMA writes {byte address, data}, in order.
  logic [23:0] exp_q[$];
  int          n_wr = 0;

  task automatic plan_copy(input logic [15:0] src, input logic [15:0] dst, input int len,
                           input bit fill);
    logic [15:0] s, d;
    logic [7:0]  b;
    for (int i = 0; i < len; i++) begin
      s = src + 16'(i);
      d = dst + 16'(i);
      b = fill ? src[7:0] : ref_mem[s];
      ref_mem[d] = b;
      exp_q.push_back({d, b});
    end
  endtask

  // CPU driver: 0 quiet, 1 always active, 2 random activity
  int cpu_mode = 0;

  always @(posedge clk) begin
    #2;
    cpu_active          = (cpu_mode == 1) || ((cpu_mode == 2) && ($urandom_range(2) == 0));
    cpu_read_addr_even  = 15'($urandom);
    cpu_read_addr_odd   = 15'($urandom);
    // CPU writes are kept to bytes 0xE000..0xFFFF, away from DMA source regions.
    cpu_write_addr_even = {3'b111, 12'($urandom)};
    cpu_write_addr_odd  = {3'b111, 12'($urandom)};
    cpu_write_en_even   = cpu_active && ($urandom_range(1) == 1);
    cpu_write_en_odd    = cpu_active && ($urandom_range(1) == 1);
    cpu_write_data_even = 8'($urandom);
    cpu_write_data_odd  = 8'($urandom);
  end

  logic [77:0] mem_vec, cpu_vec;
  assign mem_vec = {mem_read_addr_even, mem_read_addr_odd, mem_write_addr_even,
                    mem_write_addr_odd, mem_write_en_even, mem_write_en_odd,
                    mem_write_data_even, mem_write_data_odd};
  assign cpu_vec = {cpu_read_addr_even, cpu_read_addr_odd, cpu_write_addr_even,
                    cpu_write_addr_odd, cpu_write_en_even, cpu_write_en_odd,
                    cpu_write_data_even, cpu_write_data_odd};

  logic [15:0] mon_a;
  logic [7:0]  mon_d;
  logic [23:0] mon_e;

  // Port monitor: CPU priority / idle pass-through, and every DMA write against the plan.
  always @(negedge clk) begin
    if (cpu_active || !busy) check("mirror", mem_vec, cpu_vec);
    if (!cpu_active && (mem_write_en_even || mem_write_en_odd)) begin
      n_wr++;
      check("wr_one_lane", mem_write_en_even & mem_write_en_odd, 1'b0);
      mon_a = mem_write_en_odd ? {mem_write_addr_odd, 1'b1} : {mem_write_addr_even, 1'b0};
      mon_d = mem_write_en_odd ? mem_write_data_odd : mem_write_data_even;
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr_data", {mon_a, mon_d}, mon_e);
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_copy(input logic [15:0] src, input logic [15:0] dst, input int len,
                            input bit fill);
    cfg_write(2'd0, src);
    cfg_write(2'd1, dst);
    cfg_write(2'd2, 16'(len));
    plan_copy(src, dst, len, fill);
    cfg_write(2'd3, {13'd0, fill, 2'b01});
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  int c, base;
  logic [15:0] rs, rd;
  int rl;

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_irq", irq, 1'b0);
    reset_n = 1'b1;

    // Zero length: done next cycle, irq one cycle later, no memory write
    cfg_write(2'd2, 16'd0);
    cfg_write(2'd3, 16'h0003);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_irq_early", irq, 1'b0);
    @(posedge clk); #1;
    check("len0_irq", irq, 1'b1);
    cfg_write(2'd3, 16'h0000);
    @(posedge clk); #1;
    check("irq_off", irq, 1'b0);

    // Cross-lane copy, 3 cycles per byte
    base = n_wr;
    start_copy(16'h2000, 16'h3001, 4, 1'b0);
    check("copy4_busy", busy, 1'b1);
    check("copy4_done_clr", done, 1'b0);
    wait_done("copy4", 100, c);
    check("copy4_cycles", c, 12);
    check("copy4_idle", busy, 1'b0);
    check("copy4_writes", n_wr - base, 4);
    check("copy4_drained", exp_q.size(), 0);

    // Destination wraps from 0xFFFF to 0x0000
    start_copy(16'h4000, 16'hFFFF, 2, 1'b0);
    wait_done("wrap", 100, c);
    check("wrap_cycles", c, 6);
    check("wrap_drained", exp_q.size(), 0);

    // CPU holds the port for 5 cycles during WRITE
    start_copy(16'h5003, 16'h5100, 1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_mode = 1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_busy", busy, 1'b1);
    check("stall_pending", exp_q.size(), 1);
    cpu_mode = 0;
    wait_done("stall", 100, c);
    check("stall_cycles", 7 + c, 8);
    check("stall_drained", exp_q.size(), 0);

    // Abort after 2 of 6 bytes, then resume from the retained progress
    base = n_wr;
    start_copy(16'hB000, 16'hB800, 6, 1'b0);
    c = 0;
    while (n_wr - base < 2 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    cfg_write(2'd3, 16'h0008);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_writes", n_wr - base, 2);
    check("abort_left", exp_q.size(), 4);
    cfg_write(2'd3, 16'h0001);
    wait_done("resume", 100, c);
    check("resume_cycles", c, 12);
    check("resume_writes", n_wr - base, 6);
    check("resume_drained", exp_q.size(), 0);

    // Start and abort together in IDLE: no transfer
    base = n_wr;
    cfg_write(2'd2, 16'd3);
    cfg_write(2'd3, 16'h0009);
    check("startabort_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("startabort_writes", n_wr - base, 0);

`ifdef DMA_ARBITER_FILL_EN
    start_copy(16'h00A5, 16'h2100, 3, 1'b1);
    wait_done("fill", 100, c);
    check("fill_cycles", c, 3);
    check("fill_drained", exp_q.size(), 0);
`endif

    // Random copies under random CPU traffic
    cpu_mode = 2;
    for (int t = 0; t < 20; t++) begin
      rs = 16'($urandom_range(16'h9FFF));
      rd = 16'($urandom_range(16'h9FFF));
      rl = $urandom_range(12, 1);
      base = n_wr;
      start_copy(rs, rd, rl, 1'b0);
      wait_done("rand", 3000, c);
      check("rand_writes", n_wr - base, rl);
      check("rand_drained", exp_q.size(), 0);
    end
    cpu_mode = 0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a WRITE cycle abandons the transfer
    base = n_wr;
    start_copy(16'hC000, 16'hC800, 8, 1'b0);
    c = 0;
    while (n_wr - base < 1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_writes", n_wr - base, 1);
    check("midrst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
